// File: rtl/booth_mac_accum.sv
// rtl/booth_mac_accum.sv - saturating accumulator summing N Booth products per result
// Accepts signed products on a valid/ready handshake and emits one dot-product term per group.
module booth_mac_accum #(
    parameter int PROD_W = 9,
    parameter int ACC_W  = 16,
    parameter int N      = 4,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic {ST_ACC, ST_DONE} state_t;

    localparam int EXT_W = ACC_W + 1 - PROD_W;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(N - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;

    logic [ACC_W:0]     sum;
    logic               pos_ovf;
    logic               neg_ovf;
    logic [ACC_W-1:0]   sum_clamped;

    // One guard bit: a mismatch between the top two bits means the add left the ACC_W range.
    always_comb begin
        sum     = {{EXT_W{in_product[PROD_W-1]}}, in_product} + {acc_q[ACC_W-1], acc_q};
        pos_ovf = !sum[ACC_W] && sum[ACC_W-1];
        neg_ovf = sum[ACC_W] && !sum[ACC_W-1];
        if (pos_ovf) begin
            sum_clamped = ACC_MAX;
        end else if (neg_ovf) begin
            sum_clamped = ACC_MIN;
        end else begin
            sum_clamped = sum[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (clear) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            count_d     = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
        end else if (state_q == ST_ACC) begin
            if (in_valid) begin
                if (count_q == LAST) begin
                    out_data_d  = sum_clamped;
                    out_sat_d   = sat_q | pos_ovf | neg_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    count_d     = '0;
                    sat_d       = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    acc_d   = sum_clamped;
                    count_d = count_q + CNT_W'(1);
                    sat_d   = sat_q | pos_ovf | neg_ovf;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign count     = count_q;

endmodule

// File: tb/tb_booth_mac_accum.sv
// tb/tb_booth_mac_accum.sv - scoreboard bench for booth_mac_accum (default and 10-bit accumulator)
module tb_booth_mac_accum;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_product = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;
    logic [2:0]  count;

    logic        b_clear = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [8:0]  b_in_product = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [9:0]  b_out_data;
    logic        b_out_sat;
    logic [2:0]  b_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] q_a[$];
    logic [10:0] q_b[$];

    booth_mac_accum dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .count(count)
    );

    booth_mac_accum #(.PROD_W(9), .ACC_W(10), .N(4)) dut_b (
        .clk(clk), .resetn(resetn), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_sat(b_out_sat), .count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input int p);
        int t;
        logic [31:0] pv;
        pv = p;
        t = 0;
        if (sel == 0) begin
            in_valid = 1'b1;
            in_product = pv[8:0];
        end else begin
            b_in_valid = 1'b1;
            b_in_product = pv[8:0];
        end
        while (((sel == 0) ? !in_ready : !b_in_ready) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        tick();
        if (sel == 0) in_valid = 1'b0;
        else b_in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready && !clear) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_result", 1, 0);
            end else begin
                logic [16:0] e;
                e = q_a.pop_front();
                chk("a_out_data", int'(out_data), int'(e[15:0]));
                chk("a_out_sat", int'(out_sat), int'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && b_out_valid && b_out_ready && !b_clear) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_result", 1, 0);
            end else begin
                logic [10:0] e;
                e = q_b.pop_front();
                chk("b_out_data", int'(b_out_data), int'(e[9:0]));
                chk("b_out_sat", int'(b_out_sat), int'(e[10]));
            end
        end
    end

    initial begin
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        tick();
        resetn = 1'b1;
        tick();

        // back-to-back group 3, -5, 49, -64 -> -17
        out_ready = 1'b1;
        q_a.push_back({1'b0, 16'hFFEF});
        send(0, 3);
        send(0, -5);
        send(0, 49);
        send(0, -64);
        chk("t1_out_valid_rise", int'(out_valid), 1);
        chk("t1_in_ready_low", int'(in_ready), 0);
        tick();
        chk("t1_out_valid_fall", int'(out_valid), 0);
        chk("t1_in_ready_back", int'(in_ready), 1);

        // backpressure with ignored extra in_valid
        out_ready = 1'b0;
        q_a.push_back({1'b0, 16'd4});
        for (int i = 0; i < 4; i++) send(0, 1);
        in_valid = 1'b1;
        in_product = 9'd77;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_data", int'(out_data), 4);
            chk("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_handoff_valid", int'(out_valid), 0);
        chk("bp_in_ready_next", int'(in_ready), 1);
        chk("bp_count_ignored", int'(count), 0);

        // saturation on 10-bit accumulator
        q_b.push_back({1'b1, 10'd411});
        send(1, 200);
        send(1, 200);
        send(1, 200);
        chk("sat_count3", int'(b_count), 3);
        send(1, -100);
        q_b.push_back({1'b0, 10'd4});
        for (int i = 0; i < 4; i++) send(1, 1);
        q_b.push_back({1'b1, 10'h200});
        for (int i = 0; i < 4; i++) send(1, -256);
        tick();

        // clear mid-group
        send(0, 10);
        send(0, 10);
        chk("clr_count2", int'(count), 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count0", int'(count), 0);
        q_a.push_back({1'b0, 16'd40});
        for (int i = 0; i < 4; i++) send(0, 10);
        tick();

        // clear while result pending discards it
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 1);
        chk("clr_pending_valid", int'(out_valid), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_drop_valid", int'(out_valid), 0);
        chk("clr_in_ready", int'(in_ready), 1);
        chk("clr_out_data_kept", int'(out_data), 4);
        out_ready = 1'b1;
        tick();

        // async reset mid-group
        send(0, 5);
        send(0, 5);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_grp_count", int'(count), 0);
        chk("arst_grp_out_data", int'(out_data), 0);
        chk("arst_grp_in_ready", int'(in_ready), 1);
        tick();
        resetn = 1'b1;
        tick();

        // async reset while result pending
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 1);
        chk("arst_done_pre_valid", int'(out_valid), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_done_valid", int'(out_valid), 0);
        chk("arst_done_data", int'(out_data), 0);
        chk("arst_done_sat", int'(out_sat), 0);
        chk("arst_done_in_ready", int'(in_ready), 1);
        tick();
        resetn = 1'b1;
        out_ready = 1'b1;
        tick();

        q_a.push_back({1'b0, 16'd2});
        send(0, 7);
        send(0, -7);
        send(0, 2);
        send(0, 0);
        for (int i = 0; i < 4; i++) tick();

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_mac_accum.md
Name: booth_mac_accum

Overview:
- Downstream consumer of the radix-4 Booth multiplier.
- Accepts signed products over a valid/ready handshake and sums N consecutive products into a wider signed accumulator with saturation.
- Presents each completed dot-product result on a valid/ready output handshake.
- Sits between the multiplier and the filter/MAC datapath that consumes dot-product terms.

Parameters:
- PROD_W, 9, width of the signed product input (matches the multiplier's 9-bit product).
- ACC_W, 16, width of the signed accumulator and result. Must be > PROD_W.
- N, 4, number of products summed per result. Must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort/flush of the current group.
- in_valid  input  1  product available.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  PROD_W  signed two's-complement product.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  ACC_W  signed accumulated result.
- out_sat  output  1  at least one saturation occurred in this group.
- count  output  $clog2(N+1)  products accepted so far in the current group.

Behaviour:
- Reset (resetn low, async):
  - State ACC; acc=0; count=0; sat_sticky=0.
  - out_valid=0; out_data=0; out_sat=0.
  - in_ready follows state, so it is 1 once state is ACC.
- States: ACC and DONE. in_ready = (state==ACC), combinational from state only. in_ready never depends on out_ready.
- Accept: in_valid && in_ready at a rising edge.
  - Sign-extend in_product to ACC_W+1 bits and add to acc (also sign-extended to ACC_W+1).
  - If sum > 2^(ACC_W-1)-1, clamp to that value and set sat_sticky.
  - If sum < -2^(ACC_W-1), clamp to that value and set sat_sticky.
  - Otherwise take the low ACC_W bits.
- Accept with count < N-1: acc <= clamped sum; count++.
- Accept with count == N-1 (final product):
  - out_data <= clamped sum; out_sat <= sat_sticky | saturation on this add; out_valid <= 1.
  - acc <= 0; count <= 0; sat_sticky <= 0; state <= DONE.
  - Latency: out_valid rises the cycle after the final accept.
- N=1: every accept produces a result directly.
- DONE:
  - in_ready=0.
  - out_valid, out_data and out_sat stay stable until out_ready.
  - On out_ready: out_valid <= 0; state <= ACC. in_ready is 1 the next cycle, giving one mandatory bubble.
  - out_data and out_sat hold their last values after handoff.
- in_valid while in_ready=0: ignored. Upstream holds in_product until accepted.
- clear (priority over accept and output handshake):
  - acc=0; count=0; sat_sticky=0; out_valid=0; state=ACC.
  - A pending result is discarded.
  - A product presented in the same cycle is not accepted.
  - out_data and out_sat are unchanged.
- Reset mid-group: all partial state is lost and no result is produced.
- Accumulation order does not affect the unsaturated result. Saturation is applied per add, not at the end.
- No X propagation: in_product is only sampled on accept.

Test Plan:
- Default parameters, back-to-back in_valid, out_ready=1, products 3, -5, 49, -64:
  - out_data=16'hFFEF (-17), out_sat=0.
  - out_valid high for exactly 1 cycle, 1 cycle after the 4th accept.
  - in_ready low during that cycle.
- Backpressure:
  - Complete a group of 1,1,1,1 with out_ready=0 for 5 cycles: out_valid and out_data=4 hold stable; in_ready=0; extra in_valid pulses are ignored.
  - Raise out_ready: handoff occurs, then in_ready=1 next cycle.
- Saturation (ACC_W=10), products 200, 200, 200, -100:
  - Partial sum clamps at 511 on the 3rd add; final out_data=411; out_sat=1.
  - The next group 1,1,1,1 gives out_data=4, out_sat=0.
- Negative saturation (ACC_W=10), products -256 x4:
  - out_data=-512 (10'h200), out_sat=1.
- clear after 2 accepts (count=2):
  - count returns to 0; the next 4 products 10,10,10,10 give out_data=40.
  - clear asserted while out_valid=1 drops out_valid with no handoff.
- Async reset asserted mid-group and mid-DONE:
  - All outputs return to reset values immediately, without a clock edge.
  - After release, a fresh group of 7, -7, 2, 0 gives out_data=2.
